// File: rtl/test_supervisor_pkg.sv
// rtl/test_supervisor_pkg.sv - shared types and constants for the test supervisor
package test_supervisor_pkg;

  typedef enum logic [1:0] {
    DELAY,
    RUN,
    GAP,
    DONE
  } state_t;

  localparam int MODE_PARALLEL   = 0;
  localparam int MODE_SEQUENTIAL = 1;
  localparam int CYCLE_W         = 32;

endpackage

// File: rtl/test_supervisor_timer.sv
// rtl/test_supervisor_timer.sv - loadable down-counter, expires on its last count
module test_supervisor_timer #(
  parameter int W         = 32,
  parameter int RESET_VAL = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;

  // A count of 0 never reaches 1, so a zero load value disables expiry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= W'(RESET_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == W'(1));

endmodule

// File: rtl/test_supervisor.sv
// rtl/test_supervisor.sv - sequences, watches and scores a set of test units
module test_supervisor
  import test_supervisor_pkg::*;
#(
  parameter int NUM_TESTS      = 4,
  parameter int START_DELAY    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SEQUENTIAL     = MODE_PARALLEL,
  parameter int STOP_ON_FAIL   = 0
) (
  input  logic                          clock,
  input  logic                          reset,
  output logic [NUM_TESTS-1:0]          dut_reset,
  input  logic [NUM_TESTS-1:0]          dut_fail,
  input  logic [NUM_TESTS-1:0]          dut_finish,
  output logic                          done,
  output logic                          pass,
  output logic [NUM_TESTS-1:0]          fail_mask,
  output logic [NUM_TESTS-1:0]          timeout_mask,
  output logic [$clog2(NUM_TESTS):0]    cur_test,
  output logic [CYCLE_W-1:0]            cycle_count
);

  localparam int CW = $clog2(NUM_TESTS) + 1;
  localparam bit SEQ = (SEQUENTIAL == MODE_SEQUENTIAL);
  localparam bit STOP = (STOP_ON_FAIL != 0);
  localparam logic [NUM_TESTS-1:0] ONE = NUM_TESTS'(1);

  state_t               state;
  logic                 tmr_load;
  logic                 tmr_expire;
  logic [NUM_TESTS-1:0] active;
  logic [NUM_TESTS-1:0] hit_fail;
  logic [NUM_TESTS-1:0] hit_any;
  logic [NUM_TESTS-1:0] to_hit;
  logic [NUM_TESTS-1:0] fail_nxt;
  logic [NUM_TESTS-1:0] to_nxt;
  logic                 stop_now;
  logic                 seq_event;
  logic                 seq_last;
  logic                 all_resolved;
  logic                 finish_run;

  // The same timer first measures the start delay, then serves as the watchdog.
  assign tmr_load = ((state == DELAY) && tmr_expire) || (state == GAP);

  test_supervisor_timer #(
    .W         (CYCLE_W),
    .RESET_VAL (START_DELAY)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (CYCLE_W'(TIMEOUT_CYCLES)),
    .expire   (tmr_expire)
  );

  // A unit is only listened to while it is released; a result beats the watchdog.
  always_comb begin
    active       = (state == RUN) ? ~dut_reset : '0;
    hit_fail     = active & dut_fail;
    hit_any      = active & (dut_fail | dut_finish);
    to_hit       = (tmr_expire && (state == RUN)) ? (active & ~hit_any) : '0;
    fail_nxt     = fail_mask | hit_fail;
    to_nxt       = timeout_mask | to_hit;
    stop_now     = STOP && (|hit_fail);
    seq_event    = |(hit_any | to_hit);
    seq_last     = (cur_test == CW'(NUM_TESTS - 1));
    all_resolved = &(dut_reset | hit_any | to_hit);
    finish_run   = 1'b0;
    if (state == RUN) begin
      if (SEQ) begin
        finish_run = seq_event && (stop_now || seq_last);
      end else begin
        finish_run = stop_now || all_resolved;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= DELAY;
      dut_reset    <= '1;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail_mask    <= '0;
      timeout_mask <= '0;
      cur_test     <= '0;
      cycle_count  <= '0;
    end else begin
      if (((state == RUN) || (state == GAP)) && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CYCLE_W'(1);
      end
      case (state)
        DELAY: begin
          if (tmr_expire) begin
            state     <= RUN;
            dut_reset <= SEQ ? ~ONE : '0;
          end
        end
        RUN: begin
          fail_mask    <= fail_nxt;
          timeout_mask <= to_nxt;
          if (finish_run) begin
            state     <= DONE;
            done      <= 1'b1;
            pass      <= ~(|fail_nxt) & ~(|to_nxt);
            dut_reset <= '1;
          end else if (SEQ) begin
            if (seq_event) begin
              state     <= GAP;
              dut_reset <= '1;
            end
          end else begin
            dut_reset <= dut_reset | hit_any | to_hit;
          end
        end
        GAP: begin
          state     <= RUN;
          cur_test  <= cur_test + CW'(1);
          dut_reset <= ~(ONE << (cur_test + CW'(1)));
        end
        default: begin
          dut_reset <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_supervisor.sv
// tb/tb_test_supervisor.sv - directed checks of the test supervisor in several configurations
module tb_test_supervisor;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] p_rst, p_fail, p_fin, p_fm, p_tm;
  logic [3:0] t_rst, t_fail, t_fin, t_fm, t_tm;
  logic [3:0] z_rst, z_fail, z_fin, z_fm, z_tm;
  logic [2:0] s_rst, s_fail, s_fin, s_fm, s_tm;
  logic [2:0] f_rst, f_fail, f_fin, f_fm, f_tm;
  logic       p_done, p_pass, t_done, t_pass, z_done, z_pass;
  logic       s_done, s_pass, f_done, f_pass;
  logic [2:0] p_cur, t_cur, z_cur, s_cur, f_cur;
  logic [31:0] p_cc, t_cc, z_cc, s_cc, f_cc;

  test_supervisor #(.NUM_TESTS(4), .START_DELAY(16), .TIMEOUT_CYCLES(1024), .SEQUENTIAL(0), .STOP_ON_FAIL(0)) u_par (
    .clock(clock), .reset(reset), .dut_reset(p_rst), .dut_fail(p_fail), .dut_finish(p_fin),
    .done(p_done), .pass(p_pass), .fail_mask(p_fm), .timeout_mask(p_tm), .cur_test(p_cur), .cycle_count(p_cc));

  test_supervisor #(.NUM_TESTS(4), .START_DELAY(16), .TIMEOUT_CYCLES(8), .SEQUENTIAL(0), .STOP_ON_FAIL(0)) u_to (
    .clock(clock), .reset(reset), .dut_reset(t_rst), .dut_fail(t_fail), .dut_finish(t_fin),
    .done(t_done), .pass(t_pass), .fail_mask(t_fm), .timeout_mask(t_tm), .cur_test(t_cur), .cycle_count(t_cc));

  test_supervisor #(.NUM_TESTS(4), .START_DELAY(16), .TIMEOUT_CYCLES(0), .SEQUENTIAL(0), .STOP_ON_FAIL(0)) u_to0 (
    .clock(clock), .reset(reset), .dut_reset(z_rst), .dut_fail(z_fail), .dut_finish(z_fin),
    .done(z_done), .pass(z_pass), .fail_mask(z_fm), .timeout_mask(z_tm), .cur_test(z_cur), .cycle_count(z_cc));

  test_supervisor #(.NUM_TESTS(3), .START_DELAY(16), .TIMEOUT_CYCLES(1024), .SEQUENTIAL(1), .STOP_ON_FAIL(0)) u_seq (
    .clock(clock), .reset(reset), .dut_reset(s_rst), .dut_fail(s_fail), .dut_finish(s_fin),
    .done(s_done), .pass(s_pass), .fail_mask(s_fm), .timeout_mask(s_tm), .cur_test(s_cur), .cycle_count(s_cc));

  test_supervisor #(.NUM_TESTS(3), .START_DELAY(16), .TIMEOUT_CYCLES(1024), .SEQUENTIAL(1), .STOP_ON_FAIL(1)) u_sof (
    .clock(clock), .reset(reset), .dut_reset(f_rst), .dut_fail(f_fail), .dut_finish(f_fin),
    .done(f_done), .pass(f_pass), .fail_mask(f_fm), .timeout_mask(f_tm), .cur_test(f_cur), .cycle_count(f_cc));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    p_fail = '0; p_fin = '0; t_fail = '0; t_fin = '0; z_fail = '0; z_fin = '0;
    s_fail = '0; s_fin = '0; f_fail = '0; f_fin = '0;
  endtask

  // Leaves every instance in its first RUN cycle.
  task automatic go_run();
    reset = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    tests_run++; if (p_rst !== 4'b1111) begin tests_failed++; $display("FAIL reset_dut_reset got %b expected 1111", p_rst); end
    tests_run++; if ({p_done, p_pass} !== 2'b00) begin tests_failed++; $display("FAIL reset_done_pass got %b expected 00", {p_done, p_pass}); end
    tests_run++; if ({p_fm, p_tm} !== 8'h00) begin tests_failed++; $display("FAIL reset_masks got %h expected 00", {p_fm, p_tm}); end
    tests_run++; if (p_cc !== 32'd0 || s_cur !== 3'd0) begin tests_failed++; $display("FAIL reset_counters got cc=%0d cur=%0d expected 0 0", p_cc, s_cur); end
  endtask

  task automatic test_parallel_pass();
    go_run();
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin
        tests_run++; if (p_rst !== 4'b0000) begin tests_failed++; $display("FAIL par_release got %b expected 0000", p_rst); end
      end
      if (c == 4) begin
        tests_run++; if (p_rst !== 4'b0001) begin tests_failed++; $display("FAIL par_reassert got %b expected 0001", p_rst); end
      end
      if (c == 9) begin
        tests_run++; if (p_done !== 1'b0) begin tests_failed++; $display("FAIL par_early_done got %b expected 0", p_done); end
      end
      p_fin = (c == 3) ? 4'b0001 : (c == 5) ? 4'b0010 : (c == 7) ? 4'b0100 : (c == 9) ? 4'b1000 : 4'b0000;
      tick();
      p_fin = '0;
    end
    tests_run++; if ({p_done, p_pass} !== 2'b11) begin tests_failed++; $display("FAIL par_done_pass got %b expected 11", {p_done, p_pass}); end
    tests_run++; if ({p_fm, p_tm} !== 8'h00) begin tests_failed++; $display("FAIL par_masks got %h expected 00", {p_fm, p_tm}); end
    tests_run++; if (p_cc !== 32'd10) begin tests_failed++; $display("FAIL par_cycle_count got %0d expected 10", p_cc); end
    tests_run++; if (p_rst !== 4'b1111 || p_cur !== 3'd0) begin tests_failed++; $display("FAIL par_done_state got rst=%b cur=%0d expected 1111 0", p_rst, p_cur); end
  endtask

  task automatic test_fail_priority();
    go_run();
    for (int c = 0; c < 7; c++) begin
      if (c == 4) begin
        tests_run++; if (p_fm !== 4'b0100) begin tests_failed++; $display("FAIL prio_fail_latency got %b expected 0100", p_fm); end
        tests_run++; if (p_rst !== 4'b0111) begin tests_failed++; $display("FAIL prio_reassert got %b expected 0111", p_rst); end
      end
      p_fail = (c == 3) ? 4'b0100 : (c == 5) ? 4'b0010 : 4'b0000;
      p_fin  = (c == 2) ? 4'b0001 : (c == 3) ? 4'b0110 : (c == 6) ? 4'b1000 : 4'b0000;
      tick();
      p_fail = '0;
      p_fin = '0;
    end
    tests_run++; if ({p_done, p_pass} !== 2'b10) begin tests_failed++; $display("FAIL prio_done_pass got %b expected 10", {p_done, p_pass}); end
    tests_run++; if (p_fm !== 4'b0100 || p_tm !== 4'b0000) begin tests_failed++; $display("FAIL prio_masks got fm=%b tm=%b expected 0100 0000", p_fm, p_tm); end
  endtask

  task automatic test_timeout();
    go_run();
    for (int c = 0; c < 8; c++) begin
      if (c == 7) begin
        tests_run++; if ({t_done, t_tm} !== 5'b0_0000) begin tests_failed++; $display("FAIL to_early got %b expected 00000", {t_done, t_tm}); end
      end
      t_fin = (c == 1) ? 4'b0111 : 4'b0000;
      z_fin = t_fin;
      tick();
      t_fin = '0;
      z_fin = '0;
    end
    tests_run++; if (t_tm !== 4'b1000 || t_fm !== 4'b0000) begin tests_failed++; $display("FAIL to_masks got tm=%b fm=%b expected 1000 0000", t_tm, t_fm); end
    tests_run++; if ({t_done, t_pass} !== 2'b10) begin tests_failed++; $display("FAIL to_done_pass got %b expected 10", {t_done, t_pass}); end
    tests_run++; if (t_cc !== 32'd8) begin tests_failed++; $display("FAIL to_cycle_count got %0d expected 8", t_cc); end
    repeat (40) tick();
    tests_run++; if ({z_done, z_tm} !== 5'b0_0000) begin tests_failed++; $display("FAIL to0_never_done got %b expected 00000", {z_done, z_tm}); end
    // A fail arriving on the expiry cycle must be scored as a fail, not a timeout.
    go_run();
    for (int c = 0; c < 8; c++) begin
      t_fin  = (c == 1) ? 4'b0111 : 4'b0000;
      t_fail = (c == 7) ? 4'b1000 : 4'b0000;
      tick();
      t_fin = '0;
      t_fail = '0;
    end
    tests_run++; if ({t_fm, t_tm} !== 8'b1000_0000) begin tests_failed++; $display("FAIL to_result_wins got fm=%b tm=%b expected 1000 0000", t_fm, t_tm); end
    tests_run++; if (t_done !== 1'b1) begin tests_failed++; $display("FAIL to_result_done got %b expected 1", t_done); end
  endtask

  task automatic test_sequential();
    logic [2:0] exp_rst [9];
    logic [2:0] exp_cur [9];
    logic [2:0] fin     [9];
    exp_rst = '{3'b110, 3'b110, 3'b111, 3'b101, 3'b101, 3'b111, 3'b011, 3'b011, 3'b111};
    exp_cur = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};
    fin     = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100, 3'b000};
    go_run();
    for (int c = 0; c < 9; c++) begin
      tests_run++; if (s_rst !== exp_rst[c]) begin tests_failed++; $display("FAIL seq_dut_reset c=%0d got %b expected %b", c, s_rst, exp_rst[c]); end
      tests_run++; if (s_cur !== exp_cur[c]) begin tests_failed++; $display("FAIL seq_cur_test c=%0d got %0d expected %0d", c, s_cur, exp_cur[c]); end
      s_fin = fin[c];
      s_fail = (c == 0) ? 3'b100 : 3'b000;
      tick();
      s_fin = '0;
      s_fail = '0;
    end
    tests_run++; if ({s_done, s_pass} !== 2'b11) begin tests_failed++; $display("FAIL seq_done_pass got %b expected 11", {s_done, s_pass}); end
    tests_run++; if ({s_fm, s_tm} !== 6'b000_000) begin tests_failed++; $display("FAIL seq_masks got fm=%b tm=%b expected 000 000", s_fm, s_tm); end
    tests_run++; if (s_cc !== 32'd8) begin tests_failed++; $display("FAIL seq_cycle_count got %0d expected 8", s_cc); end
  endtask

  task automatic test_stop_on_fail();
    logic released2;
    go_run();
    f_fin = 3'b001;
    tick();
    f_fin = '0;
    tick();
    tests_run++; if (f_rst !== 3'b101) begin tests_failed++; $display("FAIL sof_second_test got %b expected 101", f_rst); end
    f_fail = 3'b010;
    tick();
    f_fail = '0;
    tests_run++; if ({f_done, f_pass} !== 2'b10) begin tests_failed++; $display("FAIL sof_done_pass got %b expected 10", {f_done, f_pass}); end
    tests_run++; if (f_fm !== 3'b010 || f_tm !== 3'b000) begin tests_failed++; $display("FAIL sof_masks got fm=%b tm=%b expected 010 000", f_fm, f_tm); end
    tests_run++; if (f_cur !== 3'd1) begin tests_failed++; $display("FAIL sof_cur_test got %0d expected 1", f_cur); end
    released2 = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (f_rst !== 3'b111) released2 = 1'b1;
      tick();
    end
    tests_run++; if (released2 !== 1'b0) begin tests_failed++; $display("FAIL sof_test2_released got %b expected 0", released2); end
  endtask

  task automatic test_reset_mid_run();
    go_run();
    p_fail = 4'b0001;
    tick();
    p_fail = '0;
    tick();
    tick();
    tests_run++; if (p_fm !== 4'b0001) begin tests_failed++; $display("FAIL mid_pre_verdict got %b expected 0001", p_fm); end
    reset = 1'b0;
    #1;
    tests_run++; if (p_rst !== 4'b1111 || p_fm !== 4'b0000) begin tests_failed++; $display("FAIL mid_async got rst=%b fm=%b expected 1111 0000", p_rst, p_fm); end
    tests_run++; if ({p_done, p_pass} !== 2'b00 || p_cc !== 32'd0) begin tests_failed++; $display("FAIL mid_async_out got dp=%b cc=%0d expected 00 0", {p_done, p_pass}, p_cc); end
    #1;
    reset = 1'b1;
    repeat (15) tick();
    tests_run++; if (p_rst !== 4'b1111) begin tests_failed++; $display("FAIL mid_delay_hold got %b expected 1111", p_rst); end
    tick();
    tests_run++; if (p_rst !== 4'b0000) begin tests_failed++; $display("FAIL mid_release got %b expected 0000", p_rst); end
  endtask

  initial begin
    test_reset();
    test_parallel_pass();
    test_fail_priority();
    test_timeout();
    test_sequential();
    test_stop_on_fail();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
